// File: rtl/psl_read_issuer.sv
// psl_read_issuer: streams cache-line read commands for a PSL job, paced by
// command credits and an in-flight cap, and reports finished/abort to job control.
module psl_read_issuer #(
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter logic [12:0] READ_CMD        = 13'h0A00,
  parameter int unsigned LINE_BYTES      = 128
) (
  input  logic        ha_pclock,
  input  logic        rst,
  input  logic        ah_jrunning,
  input  logic [63:0] wed,
  input  logic [7:0]  num_credits,
  input  logic [15:0] req_lines,
  input  logic        reset_cmd_received,
  output logic        ah_cvalid,
  output logic [12:0] ah_com,
  output logic        ah_compar,
  output logic [7:0]  ah_ctag,
  output logic        ah_ctagpar,
  output logic [63:0] ah_cea,
  output logic        ah_ceapar,
  output logic [11:0] ah_csize,
  input  logic        ha_rvalid,
  input  logic [7:0]  ha_rtag,
  input  logic [7:0]  ha_response,
  input  logic [8:0]  ha_rcredits,
  output logic        finished,
  output logic        abort,
  output logic [7:0]  outstanding
);
  localparam logic [7:0]  MAX_OUT = 8'(MAX_OUTSTANDING);
  localparam logic [11:0] CSIZE   = 12'(LINE_BYTES);
  localparam logic [63:0] STRIDE  = 64'(LINE_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_DONE, S_FAIL, S_FLUSH
  } state_t;

  state_t            state_q, state_d;
  logic              jr_q;
  logic [15:0]       issued_q, issued_d, completed_q, completed_d, lines_q, lines_d;
  logic [7:0]        out_q, out_d;
  logic signed [9:0] credits_q, credits_d, rcred_ext;
  logic [63:0]       base_q, base_d;
  logic              fail_q, fail_d;

  logic              cvalid_d, finished_d, abort_d;
  logic [12:0]       com_d;
  logic              compar_d, ctagpar_d, ceapar_d;
  logic [7:0]        ctag_d;
  logic [63:0]       cea_d;
  logic [11:0]       csize_d;

  logic start, accept, resp_fail, issue;
  logic unused_ok;

  assign unused_ok = ^{ha_rtag, wed[6:0]};
  assign rcred_ext = {ha_rcredits[8], ha_rcredits};

  assign start     = (state_q == S_IDLE) && !jr_q && ah_jrunning;
  assign accept    = ha_rvalid && (state_q != S_IDLE);
  assign resp_fail = accept && (ha_response != 8'h00);
  assign issue     = (state_q == S_ISSUE) && (credits_q > 10'sd0) && (out_q < MAX_OUT) &&
                     (issued_q < lines_q) && !reset_cmd_received && !resp_fail;

  // Job counters; a response and an issue in the same cycle apply both deltas.
  always_comb begin
    issued_d    = issued_q;
    completed_d = completed_q;
    lines_d     = lines_q;
    out_d       = out_q;
    credits_d   = credits_q;
    base_d      = base_q;
    fail_d      = fail_q;
    if (start) begin
      issued_d    = '0;
      completed_d = '0;
      out_d       = '0;
      fail_d      = 1'b0;
      credits_d   = {2'b00, num_credits};
      base_d      = {wed[63:7], 7'b0};
      lines_d     = req_lines;
    end else begin
      if (issue) begin
        issued_d  = issued_q + 16'd1;
        out_d     = out_d + 8'd1;
        credits_d = credits_d - 10'sd1;
      end
      if (accept) begin
        completed_d = completed_q + 16'd1;
        credits_d   = credits_d + rcred_ext;
        if (out_q != '0 || issue) out_d = out_d - 8'd1;
        if (resp_fail) fail_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (req_lines == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (resp_fail) state_d = S_FAIL;
        else if (issue && issued_d == lines_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (resp_fail) state_d = S_FAIL;
        else if (completed_d == lines_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  if (out_d == '0) state_d = S_IDLE;
      S_FLUSH: if (out_d == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (reset_cmd_received && state_q != S_IDLE) state_d = S_FLUSH;
  end

  always_comb begin
    cvalid_d   = issue;
    finished_d = (state_q == S_DONE) && !fail_q && !reset_cmd_received;
    abort_d    = (state_q == S_FAIL) && (out_d == '0) && !reset_cmd_received;
    com_d      = ah_com;
    compar_d   = ah_compar;
    ctag_d     = ah_ctag;
    ctagpar_d  = ah_ctagpar;
    cea_d      = ah_cea;
    ceapar_d   = ah_ceapar;
    csize_d    = ah_csize;
    if (issue) begin
      com_d     = READ_CMD;
      compar_d  = ~^READ_CMD;
      ctag_d    = issued_q[7:0];
      ctagpar_d = ~^issued_q[7:0];
      cea_d     = base_q + 64'(issued_q) * STRIDE;
      ceapar_d  = ~^(base_q + 64'(issued_q) * STRIDE);
      csize_d   = CSIZE;
    end
  end

  always_ff @(posedge ha_pclock or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge ha_pclock or posedge rst) begin
    if (rst) begin
      jr_q        <= 1'b0;
      issued_q    <= '0;
      completed_q <= '0;
      lines_q     <= '0;
      out_q       <= '0;
      credits_q   <= '0;
      base_q      <= '0;
      fail_q      <= 1'b0;
      ah_cvalid   <= 1'b0;
      finished    <= 1'b0;
      abort       <= 1'b0;
      ah_com      <= '0;
      ah_compar   <= 1'b1;
      ah_ctag     <= '0;
      ah_ctagpar  <= 1'b1;
      ah_cea      <= '0;
      ah_ceapar   <= 1'b1;
      ah_csize    <= '0;
    end else begin
      jr_q        <= ah_jrunning;
      issued_q    <= issued_d;
      completed_q <= completed_d;
      lines_q     <= lines_d;
      out_q       <= out_d;
      credits_q   <= credits_d;
      base_q      <= base_d;
      fail_q      <= fail_d;
      ah_cvalid   <= cvalid_d;
      finished    <= finished_d;
      abort       <= abort_d;
      ah_com      <= com_d;
      ah_compar   <= compar_d;
      ah_ctag     <= ctag_d;
      ah_ctagpar  <= ctagpar_d;
      ah_cea      <= cea_d;
      ah_ceapar   <= ceapar_d;
      ah_csize    <= csize_d;
    end
  end

  assign outstanding = out_q;

endmodule

// File: tb/tb_psl_read_issuer.sv
// Bench for psl_read_issuer: table of jobs, hand-written reset/idle sequences
// and random jobs, all checked against a transaction-level job model.
`timescale 1ns/1ps
module tb_psl_read_issuer;
  localparam int LB   = 128;
  localparam int MAXO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        ah_jrunning;
  logic [63:0] wed;
  logic [7:0]  num_credits;
  logic [15:0] req_lines;
  logic        reset_cmd_received;
  logic        ah_cvalid;
  logic [12:0] ah_com;
  logic        ah_compar;
  logic [7:0]  ah_ctag;
  logic        ah_ctagpar;
  logic [63:0] ah_cea;
  logic        ah_ceapar;
  logic [11:0] ah_csize;
  logic        ha_rvalid;
  logic [7:0]  ha_rtag;
  logic [7:0]  ha_response;
  logic [8:0]  ha_rcredits;
  logic        finished;
  logic        abort;
  logic [7:0]  outstanding;

  always #5 clk = ~clk;

  psl_read_issuer #(.MAX_OUTSTANDING(64), .READ_CMD(13'h0A00), .LINE_BYTES(128)) dut (
    .ha_pclock(clk), .rst(rst), .ah_jrunning(ah_jrunning), .wed(wed),
    .num_credits(num_credits), .req_lines(req_lines),
    .reset_cmd_received(reset_cmd_received), .ah_cvalid(ah_cvalid), .ah_com(ah_com),
    .ah_compar(ah_compar), .ah_ctag(ah_ctag), .ah_ctagpar(ah_ctagpar), .ah_cea(ah_cea),
    .ah_ceapar(ah_ceapar), .ah_csize(ah_csize), .ha_rvalid(ha_rvalid), .ha_rtag(ha_rtag),
    .ha_response(ha_response), .ha_rcredits(ha_rcredits), .finished(finished),
    .abort(abort), .outstanding(outstanding)
  );

  typedef struct {
    logic [63:0] w;
    int nc, nl, dly, cret, fail_idx, flush_at;
    int exp_iss, exp_fin, exp_abt;
  } job_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cvalid"}, ah_cvalid, 0);
    chk({tag, "_finished"}, finished, 0);
    chk({tag, "_abort"}, abort, 0);
    chk({tag, "_outstanding"}, outstanding, 0);
    chk({tag, "_ctag"}, ah_ctag, 0);
    chk({tag, "_cea"}, ah_cea, 0);
    chk({tag, "_com"}, ah_com, 0);
    chk({tag, "_compar"}, ah_compar, 1);
    chk({tag, "_ctagpar"}, ah_ctagpar, 1);
    chk({tag, "_ceapar"}, ah_ceapar, 1);
    chk({tag, "_csize"}, ah_csize, 0);
  endtask

  // Called just after a rising edge; runs one job to completion and scores it.
  task automatic run_job(input job_t jb);
    int issues, consumed, bal, peak, last_due, d, due, idx, settle;
    int fail_iter, zero_iter, last_cons, flush_iter, fin_cnt, abt_cnt, fin_iter, abt_iter;
    int due_q[$];
    int idx_q[$];
    bit rv_pend, rv_fail, stopped, inorder;
    int rv_cred;
    logic [63:0] base;
    issues = 0; consumed = 0; peak = 0; last_due = 0; settle = -1;
    fail_iter = -1; zero_iter = -1; last_cons = -1; flush_iter = -1;
    fin_cnt = 0; abt_cnt = 0; fin_iter = -1; abt_iter = -1;
    rv_pend = 0; rv_fail = 0; rv_cred = 0; stopped = 0;
    base    = jb.w & ~64'h7F;
    bal     = jb.nc;
    inorder = (jb.fail_idx < 0) && (jb.flush_at < 0) && (jb.nc >= jb.nl) && (jb.nl <= MAXO);
    wed = jb.w; num_credits = 8'(jb.nc); req_lines = 16'(jb.nl); ah_jrunning = 1'b1;
    for (int j = 1; j <= 3000 && settle != 0; j++) begin
      @(posedge clk); #1;
      if (jb.flush_at >= 0 && j == jb.flush_at + 1) begin stopped = 1; flush_iter = j; end
      if (rv_pend && rv_fail) begin stopped = 1; fail_iter = j; end
      if (stopped) chk("no_cmd_after_stop", ah_cvalid, 0);
      if (ah_cvalid) begin
        chk("credit_available", bal > 0, 1);
        chk("below_max_outstanding", (issues - consumed) < MAXO, 1);
        chk("cea", ah_cea, base + 64'(issues) * 64'(LB));
        chk("ctag", ah_ctag, 64'(issues % 256));
        chk("com", ah_com, 64'h0A00);
        chk("csize", ah_csize, 64'(LB));
        chk("compar", ah_compar, ($countones(ah_com) % 2) == 0);
        chk("ctagpar", ah_ctagpar, ($countones(ah_ctag) % 2) == 0);
        chk("ceapar", ah_ceapar, ($countones(ah_cea) % 2) == 0);
        if (inorder) chk("issue_cycle", 64'(j), 64'(issues + 2));
        d   = (jb.dly > 0) ? jb.dly : int'($urandom_range(1, 6));
        due = j + d;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        due_q.push_back(due);
        idx_q.push_back(issues);
        issues++;
        bal--;
      end
      if (rv_pend) begin
        consumed++;
        bal += rv_cred;
        last_cons = j;
      end
      if (fail_iter >= 0 && zero_iter < 0 && issues == consumed) zero_iter = j;
      if (issues - consumed > peak) peak = issues - consumed;
      chk("outstanding", outstanding, 64'(issues - consumed));
      if (finished) begin fin_cnt++; fin_iter = j; end
      if (abort)    begin abt_cnt++; abt_iter = j; end
      rv_pend = 0;
      reset_cmd_received = (j == jb.flush_at);
      ha_rvalid = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= j) begin
        void'(due_q.pop_front());
        idx     = idx_q.pop_front();
        rv_fail = (idx == jb.fail_idx);
        rv_cred = (jb.cret > 0) ? jb.cret : int'($urandom_range(1, 2));
        ha_rvalid   = 1'b1;
        ha_rtag     = 8'(idx);
        ha_response = rv_fail ? 8'h01 : 8'h00;
        ha_rcredits = 9'(rv_cred);
        rv_pend     = 1;
      end
      if (settle > 0) settle--;
      else if (settle < 0 && due_q.size() == 0 && !rv_pend &&
               (fin_cnt + abt_cnt > 0 || (flush_iter >= 0 && issues == consumed)))
        settle = 3;
    end
    chk("job_completed_in_budget", settle == 0, 1);
    if (jb.exp_iss >= 0) chk("issue_count", 64'(issues), 64'(jb.exp_iss));
    chk("finished_count", 64'(fin_cnt), 64'(jb.exp_fin));
    chk("abort_count", 64'(abt_cnt), 64'(jb.exp_abt));
    if (jb.exp_fin == 1)
      chk("finished_cycle", 64'(fin_iter), 64'((jb.nl == 0) ? 2 : last_cons + 1));
    if (jb.exp_abt == 1)
      chk("abort_cycle", 64'(abt_iter), 64'((zero_iter > fail_iter) ? zero_iter : fail_iter + 1));
    if (jb.nc >= MAXO && jb.nl > MAXO && jb.dly > MAXO)
      chk("peak_outstanding", 64'(peak), 64'(MAXO));
    ah_jrunning = 1'b0; ha_rvalid = 1'b0; reset_cmd_received = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t tbl[8];
    job_t rj;
    int   n;
    // wed, credits, lines, delay, credit return, fail idx, flush iter, exp issues/finished/abort
    tbl[0] = '{64'h1000, 4, 3, 2, 1, -1, -1, 3, 1, 0};
    tbl[1] = '{64'h2000, 2, 5, 4, 1, -1, -1, 5, 1, 0};
    tbl[2] = '{64'h3000, 4, 6, 3, 1, 1, -1, 4, 0, 1};
    tbl[3] = '{64'h4000, 8, 6, 2, 1, 0, 4, 3, 0, 0};
    tbl[4] = '{64'h5000, 3, 0, 1, 1, -1, -1, 0, 1, 0};
    tbl[5] = '{64'hFFFF_FFFF_FFFF_FF85, 4, 3, 1, 1, -1, -1, 3, 1, 0};
    tbl[6] = '{64'h8000, 200, 70, 100, 1, -1, -1, 70, 1, 0};
    tbl[7] = '{64'h0, 255, 260, 3, 1, -1, -1, 260, 1, 0};

    rst = 1'b1; ah_jrunning = 1'b0; wed = '0; num_credits = '0; req_lines = '0;
    reset_cmd_received = 1'b0; ha_rvalid = 1'b0; ha_rtag = '0; ha_response = '0;
    ha_rcredits = '0;
    repeat (2) begin @(posedge clk); #1; end
    chk_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_job(tbl[i]);

    // Async reset while draining, then a fresh job.
    wed = 64'h9000; num_credits = 8'd4; req_lines = 16'd3; ah_jrunning = 1'b1;
    n = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ah_cvalid) n++;
    end
    chk("pre_reset_issues", 64'(n), 64'd3);
    chk("pre_reset_outstanding", outstanding, 64'd3);
    rst = 1'b1; #1;
    chk_reset_vals("mid_drain_reset");
    ah_jrunning = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_job(tbl[0]);

    // Stray response and PSL reset while idle are ignored.
    ha_rvalid = 1'b1; ha_response = 8'h00; ha_rcredits = 9'd1; reset_cmd_received = 1'b1;
    @(posedge clk); #1;
    ha_rvalid = 1'b0; reset_cmd_received = 1'b0;
    chk("idle_stray_outstanding", outstanding, 0);
    chk("idle_stray_cvalid", ah_cvalid, 0);
    @(posedge clk); #1;
    chk("idle_stray_outstanding_2", outstanding, 0);
    chk("idle_stray_finished", finished, 0);
    run_job(tbl[1]);

    for (int r = 0; r < 12; r++) begin
      rj.w        = {$urandom(), $urandom()};
      rj.nl       = int'($urandom_range(1, 20));
      rj.nc       = int'($urandom_range(1, 8));
      rj.dly      = 0;
      rj.cret     = 0;
      rj.fail_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rj.nl - 1)) : -1;
      rj.flush_at = -1;
      rj.exp_iss  = (rj.fail_idx < 0) ? rj.nl : -1;
      rj.exp_fin  = (rj.fail_idx < 0) ? 1 : 0;
      rj.exp_abt  = (rj.fail_idx < 0) ? 0 : 1;
      run_job(rj);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
